// File: rtl/uart_tx_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
// The PARITY state is only reachable when TX_PARITY_EN is defined.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      PARITY
   } tx_state_t;

   // Register select values, i.e. a[3:2]
   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int unsigned ST_EMPTY     = 0;
   localparam int unsigned ST_FULL      = 1;
   localparam int unsigned ST_BUSY      = 2;
   localparam int unsigned ST_OVERFLOW  = 3;
   localparam int unsigned ST_COUNT_LSB = 8;

   localparam int unsigned CTRL_ENABLE     = 0;
   localparam int unsigned CTRL_PARITY_ODD = 1;

   // A divider of zero behaves as a one-cycle bit period.
   function automatic logic [15:0] bit_period(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialized.
// A push while full is dropped, even when a pop happens on the same edge.
module tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [3:0]       count
);

   localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == 4'd0);
   assign full    = (count == 4'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus (combinational read, write on edge).
// Optional feature macro TX_PARITY_EN adds a parity bit between data and stop.
import uart_tx_pkg::*;

module mmio_uart_tx #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [15:0] BAUD_DIV_RST = 16'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        tx
);

   logic [1:0]  reg_sel;
   logic        wr_en;
   logic        push_req;

   logic [15:0] baud_div;
   logic        enable;
   logic        overflow;
`ifdef TX_PARITY_EN
   logic        parity_odd;
`endif

   logic [7:0]  fifo_dout;
   logic        fifo_empty;
   logic        fifo_full;
   logic [3:0]  fifo_count;
   logic        pop;

   tx_state_t   state, state_n;
   logic [15:0] div_cnt, div_n;
   logic [2:0]  bit_cnt, bit_n, bit_nxt;
   logic [7:0]  tx_byte, byte_n;
   logic        tx_n;
   logic        bit_end;
   logic        start_ok;
   logic [15:0] reload;

   logic        unused_bits;

   assign reg_sel     = a[3:2];
   assign wr_en       = sel & we;
   assign push_req    = wr_en & (reg_sel == REG_TXDATA);
   assign unused_bits = ^{a[31:4], a[1:0], wd[31:16]};

   tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .din   (wd[7:0]),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_div <= BAUD_DIV_RST;
         enable   <= 1'b1;
         overflow <= 1'b0;
`ifdef TX_PARITY_EN
         parity_odd <= 1'b0;
`endif
      end else begin
         if (wr_en && reg_sel == REG_BAUDDIV) baud_div <= wd[15:0];
         if (wr_en && reg_sel == REG_CTRL) begin
            enable <= wd[CTRL_ENABLE];
`ifdef TX_PARITY_EN
            parity_odd <= wd[CTRL_PARITY_ODD];
`endif
         end
         // A dropped push wins over a same-edge clear so the loss is never hidden.
         if (push_req && fifo_full)
            overflow <= 1'b1;
         else if (wr_en && reg_sel == REG_STATUS && wd[ST_OVERFLOW])
            overflow <= 1'b0;
      end
   end

   always_comb begin
      rd = '0;
      if (sel) begin
         case (reg_sel)
            REG_STATUS: begin
               rd[ST_EMPTY]               = fifo_empty;
               rd[ST_FULL]                = fifo_full;
               rd[ST_BUSY]                = (state != IDLE);
               rd[ST_OVERFLOW]            = overflow;
               rd[ST_COUNT_LSB +: 4]      = fifo_count;
            end
            REG_BAUDDIV: rd[15:0] = baud_div;
            REG_CTRL: begin
               rd[CTRL_ENABLE] = enable;
`ifdef TX_PARITY_EN
               rd[CTRL_PARITY_ODD] = parity_odd;
`else
               rd[CTRL_PARITY_ODD] = 1'b0;
`endif
            end
            default: rd = '0;
         endcase
      end
   end

   assign bit_end  = (div_cnt == 16'd0);
   assign start_ok = ~fifo_empty & enable;
   assign reload   = bit_period(baud_div) - 16'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_byte <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_n;
         div_cnt <= div_n;
         bit_cnt <= bit_n;
         tx_byte <= byte_n;
         tx      <= tx_n;
      end
   end

   // div_cnt holds the cycles left in the current bit; it reloads from BAUDDIV at each boundary.
   always_comb begin
      state_n = state;
      div_n   = div_cnt;
      bit_n   = bit_cnt;
      byte_n  = tx_byte;
      tx_n    = tx;
      pop     = 1'b0;
      bit_nxt = bit_cnt + 3'd1;
      if (state != IDLE && !bit_end) div_n = div_cnt - 16'd1;
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (start_ok) begin
               pop     = 1'b1;
               byte_n  = fifo_dout;
               tx_n    = 1'b0;
               div_n   = reload;
               bit_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_n    = tx_byte[0];
               bit_n   = '0;
               div_n   = reload;
               state_n = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               div_n = reload;
               if (bit_cnt == 3'd7) begin
`ifdef TX_PARITY_EN
                  tx_n    = (^tx_byte) ^ parity_odd;
                  state_n = PARITY;
`else
                  tx_n    = 1'b1;
                  state_n = STOP;
`endif
               end else begin
                  bit_n = bit_nxt;
                  tx_n  = tx_byte[bit_nxt];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_n    = 1'b1;
               div_n   = reload;
               state_n = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (start_ok) begin
                  pop     = 1'b1;
                  byte_n  = fifo_dout;
                  tx_n    = 1'b0;
                  div_n   = reload;
                  bit_n   = '0;
                  state_n = START;
               end else begin
                  tx_n    = 1'b1;
                  div_n   = '0;
                  state_n = IDLE;
               end
            end
         end
         default: begin
            tx_n    = 1'b1;
            div_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: pushed bytes are queued, a line monitor decodes tx frames.
// Build with TX_PARITY_EN defined to exercise the parity frame format.
module tb_mmio_uart_tx;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] A_TXDATA  = 32'h0;
   localparam logic [31:0] A_STATUS  = 32'h4;
   localparam logic [31:0] A_BAUDDIV = 32'h8;
   localparam logic [31:0] A_CTRL    = 32'hC;
`ifdef TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] wd = '0;
   logic [31:0] rd;
   logic        tx;

   mmio_uart_tx #(
      .FIFO_DEPTH   (DEPTH),
      .BAUD_DIV_RST (16'd16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sel   (sel),
      .we    (we),
      .a     (a),
      .wd    (wd),
      .rd    (rd),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [7:0]  exp_q[$];
   int unsigned start_q[$];
   int unsigned baud_tb = 16;
   logic        odd_tb = 1'b0;
   int unsigned cyc = 0;
   int unsigned frame_start = 0;
   int unsigned frame_end = 0;
   int unsigned frames = 0;

   logic        m_in = 1'b0;
   int unsigned m_bit = 0;
   int unsigned m_left = 0;
   int unsigned last_baud = 16;
   logic        m_bits[11];
   logic        m_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Line monitor: a frame is start bit, 8 data bits LSB first, [parity], stop bit.
   // Each bit lasts the divider value that was in force just before the bit began.
   initial begin
      int unsigned per;
      logic [7:0]  b;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            m_in      = 1'b0;
            last_baud = 16;
         end else begin
            per = (last_baud == 0) ? 1 : last_baud;
            if (m_in) begin
               if (m_left == 0) begin
                  check($sformatf("frame_bit%0d", m_bit), {31'd0, m_seen}, {31'd0, m_bits[m_bit]});
                  m_bit++;
                  if (m_bit == NBITS) begin
                     m_in      = 1'b0;
                     frame_end = cyc;
                     frames++;
                  end else begin
                     m_left = per - 1;
                     m_seen = m_bits[m_bit];
                  end
               end else begin
                  m_left--;
               end
               if (m_in && tx !== m_bits[m_bit]) m_seen = tx;
            end
            if (!m_in && tx === 1'b0) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: actual=start bit required=idle line at cycle %0d", cyc);
                  b = 8'h00;
               end else begin
                  b = exp_q.pop_front();
               end
               m_bits[0] = 1'b0;
               for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
               m_bits[9] = (^b) ^ odd_tb;
               m_bits[NBITS-1] = 1'b1;
               m_in        = 1'b1;
               m_bit       = 0;
               m_left      = per - 1;
               m_seen      = tx;
               frame_start = cyc;
               start_q.push_back(cyc);
            end
            last_baud = baud_tb;
         end
      end
   end

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; a = addr; wd = data;
      @(posedge clk);
      #1;
      sel = 1'b0; we = 1'b0;
      if (addr == A_BAUDDIV) baud_tb = int'(data[15:0]);
`ifdef TX_PARITY_EN
      if (addr == A_CTRL) odd_tb = data[1];
`endif
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      sel = 1'b1; we = 1'b0; a = addr;
      #1;
      data = rd;
      sel = 1'b0;
   endtask

   task automatic push(input logic [7:0] b, input bit kept);
      if (kept) exp_q.push_back(b);
      bus_write(A_TXDATA, {24'd0, b});
   endtask

   task automatic wait_idle(input int unsigned budget, input string name);
      bit done = 1'b0;
      for (int unsigned i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0 && !m_in) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s: actual=still transmitting required=idle within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_bit(input int unsigned k, input string name);
      bit done = 1'b0;
      for (int unsigned i = 0; i < 500 && !done; i++) begin
         @(posedge clk);
         if (m_in && m_bit == k) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s: actual=bit %0d not reached required=reached within 500 cycles", name, k);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=no finish required=finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      int unsigned f0;

      repeat (3) @(negedge clk);
      #2 reset = 1'b0;

      // Reset state
      check("reset_tx", {31'd0, tx}, 32'd1);
      bus_read(A_STATUS, r);  check("reset_status", r, 32'h001);
      bus_read(A_BAUDDIV, r); check("reset_bauddiv", r, 32'd16);
      bus_read(A_CTRL, r);    check("reset_ctrl", r, 32'h1);
      bus_read(A_TXDATA, r);  check("txdata_reads_zero", r, 32'h0);
      @(negedge clk);
      sel = 1'b0; we = 1'b1; a = A_BAUDDIV; wd = 32'd5;
      #1 check("unselected_rd", rd, 32'h0);
      @(posedge clk); #1 we = 1'b0;
      bus_read(A_BAUDDIV, r); check("unselected_write_ignored", r, 32'd16);

      // Single byte at BAUDDIV=4
      bus_write(A_BAUDDIV, 32'd4);
      push(8'hA5, 1'b1);
      repeat (6) @(negedge clk);
      bus_read(A_STATUS, r); check("single_busy", {31'd0, r[2]}, 32'd1);
      wait_idle(400, "single_done");
      check("single_len", frame_end - frame_start, NBITS * 4);
      bus_read(A_STATUS, r); check("single_status_after", r, 32'h001);

      // Back-to-back at BAUDDIV=2
      bus_write(A_BAUDDIV, 32'd2);
      start_q.delete();
      push(8'h01, 1'b1);
      push(8'h02, 1'b1);
      push(8'h03, 1'b1);
      bus_read(A_STATUS, r);
      checks++;
      if (r[11:8] != 4'd2 && r[11:8] != 4'd3) begin
         errors++;
         $display("FAIL b2b_count: actual=%0d required=2 or 3", r[11:8]);
      end
      wait_idle(600, "b2b_done");
      check("b2b_frames", start_q.size(), 32'd3);
      if (start_q.size() > 0) check("b2b_len", frame_end - start_q[0], 3 * NBITS * 2);
      bus_read(A_STATUS, r); check("b2b_status_after", r, 32'h001);

      // Overflow with transmitter disabled
      bus_write(A_CTRL, 32'h0);
      bus_write(A_BAUDDIV, 32'd1);
      f0 = frames;
      for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), i < 4);
      bus_read(A_STATUS, r); check("ovf_status", r, 32'h40A);
      bus_write(A_STATUS, 32'h8);
      bus_read(A_STATUS, r); check("ovf_cleared", r, 32'h402);
      bus_write(A_CTRL, 32'h1);
      wait_idle(600, "ovf_drain");
      check("ovf_frames", frames - f0, 32'd4);
      bus_read(A_STATUS, r); check("ovf_status_after", r, 32'h001);

      // Divider zero and mid-frame divider change
      bus_write(A_BAUDDIV, 32'd0);
      push(8'h3C, 1'b1);
      wait_idle(200, "div0_done");
      check("div0_len", frame_end - frame_start, NBITS);
      bus_write(A_BAUDDIV, 32'd1);
      push(8'h96, 1'b1);
      wait_bit(3, "div_mid_bit3");
      bus_write(A_BAUDDIV, 32'd3);
      wait_idle(300, "div_mid_done");
      check("div_mid_len", frame_end - frame_start, 6 + (NBITS - 6) * 3);

      // Asynchronous reset during the data bits
      bus_write(A_BAUDDIV, 32'd4);
      push(8'h00, 1'b1);
      push(8'hFF, 1'b1);
      wait_bit(3, "rst_bit3");
      #2;
      check("pre_reset_tx", {31'd0, tx}, 32'd0);
      reset = 1'b1;
      #1;
      check("reset_tx_immediate", {31'd0, tx}, 32'd1);
      exp_q.delete();
      baud_tb = 16;
      odd_tb  = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      bus_read(A_STATUS, r);  check("rst_status", r, 32'h001);
      bus_read(A_BAUDDIV, r); check("rst_bauddiv", r, 32'd16);
      repeat (40) @(negedge clk);
      check("rst_tx_idle", {31'd0, tx}, 32'd1);

      // CTRL bit1 and parity
      bus_write(A_CTRL, 32'h3);
      bus_read(A_CTRL, r);
`ifdef TX_PARITY_EN
      check("ctrl_parity_rw", r, 32'h3);
      bus_write(A_CTRL, 32'h1);
      bus_write(A_BAUDDIV, 32'd1);
      push(8'h07, 1'b1);
      wait_idle(200, "parity_even_done");
      check("parity_even_len", frame_end - frame_start, 32'd11);
      bus_write(A_CTRL, 32'h3);
      push(8'h07, 1'b1);
      wait_idle(200, "parity_odd_done");
      check("parity_odd_len", frame_end - frame_start, 32'd11);
      bus_write(A_CTRL, 32'h1);
`else
      check("ctrl_bit1_ignored", r, 32'h1);
      bus_write(A_CTRL, 32'h1);
`endif

      // Randomized pushes and divider writes
      bus_write(A_BAUDDIV, 32'd1);
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               bus_write(A_BAUDDIV, 32'($urandom_range(0, 3)));
               bus_read(A_BAUDDIV, r);
               check("rand_bauddiv", r, 32'(baud_tb));
            end
            1, 2: begin
               bus_read(A_STATUS, r);
               if (!r[1]) push(8'($urandom), 1'b1);
            end
            default: repeat ($urandom_range(1, 6)) @(negedge clk);
         endcase
      end
      wait_idle(5000, "rand_drain");
      bus_read(A_STATUS, r); check("rand_status_after", r, 32'h001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
